// File: rtl/blink_rate_ctrl_if.sv
// rtl/blink_rate_ctrl_if.sv - button/timebase inputs and blink/rate outputs of the rear-light blink controller
interface blink_rate_ctrl_if #(
  parameter int RATE_W = 4
);
  logic              beat;
  logic              blink_en;
  logic              faster;
  logic              slower;
  logic              blink_out;
  logic [RATE_W-1:0] rate;
  logic              rate_changed;

  modport master (
    output beat, blink_en, faster, slower,
    input  blink_out, rate, rate_changed
  );

  modport slave (
    input  beat, blink_en, faster, slower,
    output blink_out, rate, rate_changed
  );
endinterface

// File: rtl/blink_rate_ctrl.sv
// rtl/blink_rate_ctrl.sv - saturating blink-rate register and ON/OFF phase sequencer
// Optional BLINK_RATE_BTN_EDGE_EN: buttons act on rising edges instead of levels.
module blink_rate_ctrl #(
  parameter int RATE_W    = 4,
  parameter int RATE_MIN  = 1,
  parameter int RATE_MAX  = 15,
  parameter int RATE_INIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  blink_rate_ctrl_if.slave    bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  localparam logic [RATE_W-1:0] MIN_V  = RATE_W'(RATE_MIN);
  localparam logic [RATE_W-1:0] MAX_V  = RATE_W'(RATE_MAX);
  localparam logic [RATE_W-1:0] INIT_V = RATE_W'(RATE_INIT);

  logic [1:0]        state, state_nxt;
  logic [RATE_W-1:0] count, count_nxt;
  logic [RATE_W-1:0] rate_q, rate_nxt;
  logic [RATE_W:0]   count_inc;
  logic              blink_q, changed_q;
  logic              f_req, s_req;

`ifdef BLINK_RATE_BTN_EDGE_EN
  logic faster_q, slower_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      faster_q <= 1'b0;
      slower_q <= 1'b0;
    end else begin
      faster_q <= bus.faster;
      slower_q <= bus.slower;
    end
  end

  assign f_req = bus.faster & ~faster_q;
  assign s_req = bus.slower & ~slower_q;
`else
  assign f_req = bus.faster;
  assign s_req = bus.slower;
`endif

  always_comb begin
    rate_nxt = rate_q;
    if (f_req && !s_req && rate_q > MIN_V)
      rate_nxt = rate_q - 1'b1;
    else if (s_req && !f_req && rate_q < MAX_V)
      rate_nxt = rate_q + 1'b1;
  end

  // Phase end is judged against the rate held before this edge, so a
  // lowered rate below count+1 simply terminates the phase on the next beat.
  assign count_inc = {1'b0, count} + 1'b1;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (bus.blink_en)
          state_nxt = ON;
      end
      ON, OFF: begin
        if (!bus.blink_en) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (bus.beat) begin
          if (count_inc >= {1'b0, rate_q}) begin
            state_nxt = (state == ON) ? OFF : ON;
            count_nxt = '0;
          end else begin
            count_nxt = count_inc[RATE_W-1:0];
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      rate_q    <= INIT_V;
      blink_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      rate_q    <= rate_nxt;
      blink_q   <= (state_nxt == ON);
      changed_q <= (rate_nxt != rate_q);
    end
  end

  assign bus.blink_out    = blink_q;
  assign bus.rate         = rate_q;
  assign bus.rate_changed = changed_q;
endmodule

// File: tb/tb_blink_rate_ctrl.sv
// tb/tb_blink_rate_ctrl.sv - randomized and directed check of blink_rate_ctrl against a behavioural model
module tb_blink_rate_ctrl;
  localparam int RATE_MIN  = 1;
  localparam int RATE_MAX  = 15;
  localparam int RATE_INIT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  blink_rate_ctrl_if #(.RATE_W(4)) bus ();

  blink_rate_ctrl #(
    .RATE_W(4), .RATE_MIN(RATE_MIN), .RATE_MAX(RATE_MAX), .RATE_INIT(RATE_INIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // model: phase 0 = dark/idle, 1 = lit half, 2 = dark half
  int m_rate, m_cnt, m_phase;
  bit m_out, m_chg, m_fq, m_sq;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update();
    bit f, s;
    int old_rate;
    if (reset) begin
      m_rate = RATE_INIT; m_cnt = 0; m_phase = 0;
      m_out = 0; m_chg = 0; m_fq = 0; m_sq = 0;
      return;
    end
`ifdef BLINK_RATE_BTN_EDGE_EN
    f = bus.faster && !m_fq;
    s = bus.slower && !m_sq;
`else
    f = bus.faster;
    s = bus.slower;
`endif
    m_fq = bus.faster;
    m_sq = bus.slower;
    old_rate = m_rate;
    if (f && !s) m_rate = (m_rate - 1 < RATE_MIN) ? RATE_MIN : m_rate - 1;
    if (s && !f) m_rate = (m_rate + 1 > RATE_MAX) ? RATE_MAX : m_rate + 1;
    m_chg = (m_rate != old_rate);
    if (m_phase == 0) begin
      if (bus.blink_en) begin m_phase = 1; m_cnt = 0; end
    end else if (!bus.blink_en) begin
      m_phase = 0; m_cnt = 0;
    end else if (bus.beat) begin
      if (m_cnt + 1 >= old_rate) begin m_phase = 3 - m_phase; m_cnt = 0; end
      else m_cnt = m_cnt + 1;
    end
    m_out = (m_phase == 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("blink_out", int'(bus.blink_out), int'(m_out));
    check("rate", int'(bus.rate), m_rate);
    check("rate_changed", int'(bus.rate_changed), int'(m_chg));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.beat = 0; bus.blink_en = 0; bus.faster = 0; bus.slower = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic press(input bit fast, input int n);
    for (int i = 0; i < n; i++) begin
      if (fast) bus.faster = 1; else bus.slower = 1;
      step();
      bus.faster = 0; bus.slower = 0;
      step();
    end
  endtask

  int ones, pulses;
  bit outs[16];

  initial begin
    bus.beat = 0; bus.blink_en = 0; bus.faster = 0; bus.slower = 0;
    do_reset();
    check("reset_rate", int'(bus.rate), RATE_INIT);
    check("reset_out", int'(bus.blink_out), 0);
    check("reset_chg", int'(bus.rate_changed), 0);

    // free-running beat: 8 lit cycles then 8 dark
    bus.blink_en = 1; bus.beat = 1;
    for (int i = 0; i < 16; i++) begin step(); outs[i] = bus.blink_out; end
    ones = 0; for (int i = 0; i < 8; i++) ones += outs[i];
    check("half_on_len", ones, 8);
    ones = 0; for (int i = 8; i < 16; i++) ones += outs[i];
    check("half_off_len", ones, 0);
    for (int i = 0; i < 4; i++) step();
    reset = 1; step(); reset = 0;
    check("mid_on_reset_out", int'(bus.blink_out), 0);
    check("mid_on_reset_rate", int'(bus.rate), 8);

    // held faster button
    do_reset();
    pulses = 0;
    bus.faster = 1;
    for (int i = 0; i < 3; i++) begin step(); pulses += bus.rate_changed; end
    bus.faster = 0; step(); pulses += bus.rate_changed;
`ifdef BLINK_RATE_BTN_EDGE_EN
    check("held_rate", int'(bus.rate), 7);
    check("held_pulses", pulses, 1);
`else
    check("held_rate", int'(bus.rate), 5);
    check("held_pulses", pulses, 3);
`endif

    // simultaneous requests cancel
    do_reset();
    bus.faster = 1; bus.slower = 1; step();
    check("both_rate", int'(bus.rate), 8);
    check("both_chg", int'(bus.rate_changed), 0);
    bus.faster = 0; bus.slower = 0;

    // saturation at both bounds
    press(1, 10);
    bus.faster = 1; step(); bus.faster = 0;
    check("min_rate", int'(bus.rate), RATE_MIN);
    check("min_chg", int'(bus.rate_changed), 0);
    step();
    press(0, 20);
    bus.slower = 1; step(); bus.slower = 0;
    check("max_rate", int'(bus.rate), RATE_MAX);
    check("max_chg", int'(bus.rate_changed), 0);
    step();

    // lowering rate mid-phase ends the lit half on the next beat
    do_reset();
    bus.blink_en = 1; bus.beat = 1; step();
    for (int i = 0; i < 5; i++) step();
    bus.beat = 0;
    press(1, 2);
    check("lowered_rate", int'(bus.rate), 6);
    check("still_on", int'(bus.blink_out), 1);
    bus.beat = 1; step();
    check("early_off", int'(bus.blink_out), 0);
    ones = 0;
    for (int i = 0; i < 5; i++) begin step(); ones += bus.blink_out; end
    check("off6_dark", ones, 0);
    step();
    check("off6_relit", int'(bus.blink_out), 1);

    // slow timebase: beat every 4th cycle at rate 2
    do_reset();
    press(1, 6);
    check("rate2", int'(bus.rate), 2);
    bus.blink_en = 1;
    for (int i = 0; i < 40; i++) begin bus.beat = (i % 4 == 3); step(); end
    bus.beat = 0; bus.blink_en = 0; step();
    check("drop_en_out", int'(bus.blink_out), 0);
    bus.blink_en = 1; step();
    check("reenable_out", int'(bus.blink_out), 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 299) == 0);
      bus.beat      = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) bus.blink_en = ~bus.blink_en;
      bus.faster    = ($urandom_range(0, 9) == 0);
      bus.slower    = ($urandom_range(0, 9) == 0);
      step();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blink_rate_ctrl.md
# blink_rate_ctrl

Controller that sequences the blinking rear-light mode of the bicycle light. Owns the blink-period state: applies `faster`/`slower` button requests to a saturating rate register, resolves simultaneous requests, and generates the ON/OFF blink phase from a beat timebase. The mode FSM enables it via `blink_en` and routes `blink_out` to `rear_light` while in blink mode.

## Interface
- `RATE_W`, 4: width of the rate register and phase counter.
- `RATE_MIN`, 1: fastest setting, in beats per half-period; must be ≥1.
- `RATE_MAX`, 15: slowest setting, in beats per half-period; must be ≤2^RATE_W−1.
- `RATE_INIT`, 8: rate value loaded at reset.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `beat` input 1: one-cycle timebase strobe that advances the phase counter.
- `blink_en` input 1: high while the mode FSM is in blink mode.
- `faster` input 1: request a shorter period (decrement rate).
- `slower` input 1: request a longer period (increment rate).
- `blink_out` output 1: registered light drive; 1 in the ON phase.
- `rate` output RATE_W: current beats per half-period.
- `rate_changed` output 1: registered one-cycle pulse when `rate` actually changed.

## Operation
- Reset values: state IDLE, `rate`=RATE_INIT, count=0, `blink_out`=0, `rate_changed`=0, button history=0.
- Request qualification:
  - `f_req`/`s_req` are the per-cycle requests; see Configuration for how they are derived.
  - f_req & !s_req: rate ← max(rate−1, RATE_MIN).
  - s_req & !f_req: rate ← min(rate+1, RATE_MAX).
  - Both high or neither high: rate holds and `rate_changed`=0.
  - `rate_changed`=1 only if the new value differs from the old one. A request at a bound gives no pulse.
- Rate updates apply regardless of `blink_en`.
- Phase FSM has three states: IDLE, ON, OFF.
  - IDLE: count=0, `blink_out`=0. If `blink_en`=1 → ON with count=0.
  - ON/OFF: if `blink_en`=0 → IDLE, with priority over everything else.
  - Else on `beat`: if count+1 ≥ rate → switch to the other phase and set count=0. Otherwise count ← count+1.
  - No `beat`: hold state and count.
- Terminal compare uses the `rate` value registered before the current edge. A rate lowered below count+1 mid-phase ends the phase on the next beat; there is no wrap or stall.
- Count is RATE_W bits wide and never exceeds RATE_MAX−1.
- `blink_out` = (state==ON), registered.

## Timing
- `blink_en` rising sampled at edge k → `blink_out`=1 from edge k (state ON after k).
- `blink_en` falling sampled at edge k → `blink_out`=0 after edge k.
- Half-period: exactly `rate` beats. With `beat` tied high and steady rate R, `blink_out` is R cycles high, then R cycles low, repeating.
- Rate request sampled at edge k → `rate` and `rate_changed` update at edge k. `rate_changed` is cleared at edge k+1 unless another change occurs.
- `reset` takes priority over all inputs at any edge, including mid-phase. The following cycle shows reset values.

## Configuration
- Macro: `BLINK_RATE_BTN_EDGE_EN`.
- Defined:
  - Registers the previous `faster`/`slower`.
  - Each request is rising-edge only: `f_req = faster & !faster_q`, and likewise for `slower`.
  - A button held N cycles gives one step.
  - Simultaneous resolution applies to the qualified pulses.
- Not defined:
  - `f_req = faster`, `s_req = slower`, as levels; upstream debounce/one-pulse is required.
  - A button held N cycles gives up to N steps, saturating.
  - No history registers are built.

## Test plan
- Reset, then `blink_en`=1 with `beat`=1 → `rate`=8, and `blink_out` runs 8 cycles 1, 8 cycles 0, repeating. Assert reset mid-ON → `blink_out`=0 and `rate`=8 next cycle.
- Edge mode, `faster` held 3 cycles → `rate` 8→7 and exactly one `rate_changed` pulse. Level mode, same stimulus → 8→5 with three pulses.
- `faster` and `slower` high in the same cycle (both rising in edge mode) → `rate` stays 8, `rate_changed`=0.
- Step to `rate`=1, then press `faster` → `rate` stays 1, no pulse. Step to 15, then press `slower` → stays 15, no pulse.
- `rate`=8, count at 5 in ON; press `faster` twice to reach `rate`=6 → ON ends on the next `beat` (count+1=6 ≥ 6), then OFF lasts 6 beats.
- `beat` every 4th cycle, `rate`=2 → `blink_out` toggles every 8 cycles. Drop `blink_en` mid-OFF → IDLE with `blink_out`=0. Re-enable → ON restarts from count 0.
